// File: rtl/pc_seq_pkg.sv
// Shared encodings for the fetch PC sequencer: FSM states, jump/branch-op codes
// shared with decode control, and branch target helpers.
package pc_seq_pkg;

  typedef enum logic {RUN = 1'b0, RESOLVE = 1'b1} state_t;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_J    = 2'b01;
  localparam logic [1:0] JMP_JR   = 2'b10;

  localparam logic [2:0] BOP_NONE = 3'b000;
  localparam logic [2:0] BOP_BEQ  = 3'b001;
  localparam logic [2:0] BOP_BNE  = 3'b010;
  localparam logic [2:0] BOP_BLEZ = 3'b011;
  localparam logic [2:0] BOP_BGTZ = 3'b100;
  localparam logic [2:0] BOP_BLTZ = 3'b101;
  localparam logic [2:0] BOP_BGEZ = 3'b110;

  function automatic logic bop_valid(input logic [2:0] bop);
    return (bop != BOP_NONE) && (bop != 3'b111);
  endfunction

  // Word offset is sign-extended before the shift so negative offsets stay negative.
  function automatic logic [31:0] br_off(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] br_target(input logic [31:0] dpc4, input logic [31:0] off);
    return dpc4 + off;
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Decode-control / imem handshake bundle between decode and the fetch PC sequencer.
interface pc_seq_if;
  logic        i_pc_dvalid;
  logic [1:0]  i_pc_jump;
  logic [2:0]  i_pc_bop;
  logic        i_pc_ifstall;
  logic [31:0] i_pc_dpc4;
  logic [31:0] i_pc_rs;
  logic [31:0] i_pc_rt;
  logic [15:0] i_pc_imm;
  logic [25:0] i_pc_index;
  logic        i_pc_hold;
  logic        i_pc_imem_ack;
  logic        o_pc_req;
  logic [31:0] o_pc_addr;
  logic [31:0] o_pc_fpc4;
  logic        o_pc_flush;
  logic        o_pc_busy;

  modport master (
    output i_pc_dvalid, i_pc_jump, i_pc_bop, i_pc_ifstall, i_pc_dpc4, i_pc_rs, i_pc_rt,
           i_pc_imm, i_pc_index, i_pc_hold, i_pc_imem_ack,
    input  o_pc_req, o_pc_addr, o_pc_fpc4, o_pc_flush, o_pc_busy
  );

  modport slave (
    input  i_pc_dvalid, i_pc_jump, i_pc_bop, i_pc_ifstall, i_pc_dpc4, i_pc_rs, i_pc_rt,
           i_pc_imm, i_pc_index, i_pc_hold, i_pc_imem_ack,
    output o_pc_req, o_pc_addr, o_pc_fpc4, o_pc_flush, o_pc_busy
  );
endinterface

// File: rtl/pc_branch_cmp.sv
// Conditional branch evaluator: (bop, rs, rt) -> taken. Zero compares look at rs only.
module pc_branch_cmp
  import pc_seq_pkg::*;
(
  input  logic [2:0]  bop,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        taken
);

  logic rs_neg, rs_zero;

  assign rs_neg  = rs[31];
  assign rs_zero = (rs == 32'd0);

  always_comb begin
    taken = 1'b0;
    case (bop)
      BOP_BEQ:  taken = (rs == rt);
      BOP_BNE:  taken = (rs != rt);
      BOP_BLEZ: taken = rs_neg | rs_zero;
      BOP_BGTZ: taken = ~rs_neg & ~rs_zero;
      BOP_BLTZ: taken = rs_neg;
      BOP_BGEZ: taken = ~rs_neg;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/f_pc_sequencer.sv
// Fetch-stage PC sequencer: owns the fetch PC, redirects on jumps, resolves branches
// one cycle after decode. Define PC_PREDICT_NT_EN to keep fetching through RESOLVE.
module f_pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  pc_seq_if.slave    bus
);

  state_t      state;
  logic [31:0] pc, dpc4_q, off_q, jump_pc;
  logic [2:0]  bop_q;
  logic        dec, do_jump, do_bop, resolve, taken, req, flush, accept;

  // Decode control is only honoured in RUN; in RESOLVE the branch still owns decode.
  assign dec     = bus.i_pc_dvalid & ~bus.i_pc_hold & (state == RUN);
  assign do_jump = dec & ((bus.i_pc_jump == JMP_J) | (bus.i_pc_jump == JMP_JR));
  assign do_bop  = dec & ~do_jump & bop_valid(bus.i_pc_bop);
  assign resolve = (state == RESOLVE) & ~bus.i_pc_hold;
  assign jump_pc = (bus.i_pc_jump == JMP_J) ? {bus.i_pc_dpc4[31:28], bus.i_pc_index, 2'b00}
                                            : {bus.i_pc_rs[31:2], 2'b00};

  pc_branch_cmp u_cmp (
    .bop   (bop_q),
    .rs    (bus.i_pc_rs),
    .rt    (bus.i_pc_rt),
    .taken (taken)
  );

`ifdef PC_PREDICT_NT_EN
  assign req   = i_rst_n & ~bus.i_pc_hold;
  assign flush = i_rst_n & (do_jump | (resolve & taken));
`else
  assign req   = i_rst_n & (state == RUN) & ~bus.i_pc_hold & ~(bus.i_pc_dvalid & bus.i_pc_ifstall);
  assign flush = i_rst_n & do_jump;
`endif

  assign accept         = req & bus.i_pc_imem_ack;
  assign bus.o_pc_req   = req;
  assign bus.o_pc_flush = flush;
  assign bus.o_pc_addr  = pc;
  assign bus.o_pc_fpc4  = pc + 32'd4;
  assign bus.o_pc_busy  = (state == RESOLVE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= RUN;
      pc     <= RESET_PC;
      dpc4_q <= 32'd0;
      off_q  <= 32'd0;
      bop_q  <= BOP_NONE;
    end else begin
      case (state)
        RUN: begin
          if (do_jump)     pc <= jump_pc;
          else if (accept) pc <= pc + 32'd4;
          if (do_bop) begin
            state  <= RESOLVE;
            dpc4_q <= bus.i_pc_dpc4;
            off_q  <= br_off(bus.i_pc_imm);
            bop_q  <= bus.i_pc_bop;
          end
        end
        RESOLVE: begin
          if (resolve) begin
            state <= RUN;
            if (taken) pc <= br_target(dpc4_q, off_q);
`ifdef PC_PREDICT_NT_EN
            else if (accept) pc <= pc + 32'd4;
`else
            else pc <= dpc4_q;
`endif
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_f_pc_sequencer.sv
// Self-checking bench for f_pc_sequencer: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural PC model.
module tb_f_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef PC_PREDICT_NT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  typedef struct {
    logic        rst_n, dv, ifs, hold, ack;
    logic [1:0]  jmp;
    logic [2:0]  bop;
    logic [31:0] dpc4, rs, rt;
    logic [15:0] imm;
    logic [25:0] idx;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_seq_if bus ();

  f_pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int total = 0, passed = 0;
  stim_t s;
  logic [31:0] m_pc = RST_PC, m_tgt = 32'd0, m_fall = 32'd0;
  logic [2:0]  m_bop = 3'd0;
  bit          m_pend = 1'b0;
  logic        smp_req, smp_flush;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic bit m_taken(input logic [2:0] b, input logic [31:0] rs, input logic [31:0] rt);
    int sv;
    sv = rs;
    case (b)
      3'd1: return rs == rt;
      3'd2: return rs != rt;
      3'd3: return sv <= 0;
      3'd4: return sv > 0;
      3'd5: return sv < 0;
      3'd6: return sv >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t t;
    t.rst_n = 1'b1; t.dv = 1'b0; t.ifs = 1'b0; t.hold = 1'b0; t.ack = 1'b1;
    t.jmp = 2'd0; t.bop = 3'd0; t.dpc4 = 32'd0; t.rs = 32'd0; t.rt = 32'd0;
    t.imm = 16'd0; t.idx = 26'd0;
    return t;
  endfunction

  // One clock: drive s, check outputs at negedge against the model, advance the model.
  task automatic tick();
    bit br_tk, acc, exp_req, exp_flush;
    int off;
    rst_n = s.rst_n;
    bus.i_pc_dvalid = s.dv;  bus.i_pc_jump = s.jmp;   bus.i_pc_bop = s.bop;
    bus.i_pc_ifstall = s.ifs; bus.i_pc_dpc4 = s.dpc4; bus.i_pc_rs = s.rs;
    bus.i_pc_rt = s.rt;      bus.i_pc_imm = s.imm;    bus.i_pc_index = s.idx;
    bus.i_pc_hold = s.hold;  bus.i_pc_imem_ack = s.ack;
    if (!s.rst_n) begin m_pc = RST_PC; m_pend = 1'b0; end
    @(negedge clk);
    br_tk     = m_pend && m_taken(m_bop, s.rs, s.rt);
    exp_req   = s.rst_n && !s.hold && (PRED || (!m_pend && !(s.dv && s.ifs)));
    exp_flush = s.rst_n && !s.hold &&
                ((!m_pend && s.dv && (s.jmp == 2'b01 || s.jmp == 2'b10)) || (PRED && br_tk));
    smp_req   = bus.o_pc_req;
    smp_flush = bus.o_pc_flush;
    chk("req",   {31'd0, bus.o_pc_req},   {31'd0, exp_req});
    chk("flush", {31'd0, bus.o_pc_flush}, {31'd0, exp_flush});
    chk("busy",  {31'd0, bus.o_pc_busy},  {31'd0, m_pend});
    chk("addr",  bus.o_pc_addr, m_pc);
    chk("fpc4",  bus.o_pc_fpc4, m_pc + 32'd4);
    @(posedge clk);
    acc = exp_req && s.ack;
    if (s.rst_n && !s.hold) begin
      if (m_pend) begin
        m_pend = 1'b0;
        if (br_tk)     m_pc = m_tgt;
        else if (!PRED) m_pc = m_fall;
        else if (acc)  m_pc = m_pc + 32'd4;
      end else if (s.dv && s.jmp == 2'b01) begin
        m_pc = (s.dpc4 & 32'hF000_0000) | ({6'd0, s.idx} << 2);
      end else if (s.dv && s.jmp == 2'b10) begin
        m_pc = s.rs & ~32'd3;
      end else begin
        if (s.dv && s.bop >= 3'd1 && s.bop <= 3'd6) begin
          m_pend = 1'b1; m_bop = s.bop; m_fall = s.dpc4;
          off    = $signed(s.imm);
          m_tgt  = s.dpc4 + 32'(off * 4);
        end
        if (acc) m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic jr_to(input logic [31:0] a);
    s = idle(); s.ack = 1'b0; s.dv = 1'b1; s.jmp = 2'b10; s.rs = a;
    tick();
    s = idle(); s.ack = 1'b0;
  endtask

  task automatic branch(input logic [2:0] b, input logic [31:0] dpc4, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [15:0] imm);
    s = idle(); s.ack = 1'b0; s.dv = 1'b1; s.bop = b; s.ifs = 1'b1;
    s.dpc4 = dpc4; s.rs = rs; s.rt = rt; s.imm = imm;
    tick();
    chk("br_busy_lit", {31'd0, bus.o_pc_busy}, 32'd1);
    tick();
    chk("br_done_lit", {31'd0, bus.o_pc_busy}, 32'd0);
    s = idle(); s.ack = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd5;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    s = idle(); s.rst_n = 1'b0;
    tick();
    chk("rst_req_lit", {31'd0, smp_req}, 32'd0);
    tick();
    s = idle();
    rst_n = 1'b1;
    #1;
    chk("addr0_lit", bus.o_pc_addr, 32'h0);
    tick(); chk("addr4_lit", bus.o_pc_addr, 32'h4);
    tick(); chk("addr8_lit", bus.o_pc_addr, 32'h8);

    jr_to(32'h104);
    branch(3'd1, 32'h104, 32'd5, 32'd5, 16'h0003);
    chk("beq_lit", bus.o_pc_addr, 32'h110);

    jr_to(32'h200);
    branch(3'd5, 32'h200, 32'h8000_0000, 32'd0, 16'hFFFF);
    chk("bltz_lit", bus.o_pc_addr, 32'h1FC);
    jr_to(32'h200);
    branch(3'd6, 32'h200, 32'h8000_0000, 32'd0, 16'hFFFF);
    chk("bgez_lit", bus.o_pc_addr, 32'h200);

    s = idle(); s.ack = 1'b0; s.dv = 1'b1; s.jmp = 2'b01; s.idx = 26'h40; s.dpc4 = 32'h3000_0010;
    tick();
    chk("j_flush_lit", {31'd0, smp_flush}, 32'd1);
    chk("j_addr_lit", bus.o_pc_addr, 32'h3000_0100);
    s = idle(); s.ack = 1'b0;
    tick();
    chk("j_noflush_lit", {31'd0, smp_flush}, 32'd0);

    s = idle(); s.ack = 1'b0; s.dv = 1'b1; s.jmp = 2'b10; s.rs = 32'h0000_1003; s.hold = 1'b1;
    tick(); tick();
    chk("jr_hold_addr_lit", bus.o_pc_addr, 32'h3000_0100);
    chk("jr_hold_flush_lit", {31'd0, smp_flush}, 32'd0);
    s.hold = 1'b0;
    tick();
    chk("jr_flush_lit", {31'd0, smp_flush}, 32'd1);
    chk("jr_addr_lit", bus.o_pc_addr, 32'h0000_1000);

    jr_to(32'hFFFF_FFFC);
    chk("wrap_pre_lit", bus.o_pc_addr, 32'hFFFF_FFFC);
    s = idle();
    tick();
    chk("wrap_lit", bus.o_pc_addr, 32'h0);

    s = idle(); s.ack = 1'b0; s.dv = 1'b1; s.bop = 3'd2; s.ifs = 1'b1; s.rs = 32'd1;
    s.dpc4 = 32'h40; s.imm = 16'h0010;
    tick();
    s = idle(); s.rst_n = 1'b0;
    tick();
    chk("rst_resolve_busy_lit", {31'd0, bus.o_pc_busy}, 32'd0);
    chk("rst_resolve_addr_lit", bus.o_pc_addr, RST_PC);
    s = idle();
    tick();

    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.rst_n = ($urandom_range(0, 99) != 0);
      s.dv    = $urandom_range(0, 3) != 0;
      s.jmp   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      s.bop   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      s.ifs   = ($urandom_range(0, 9) == 0) ? 1'($urandom_range(0, 1))
                                            : (s.bop >= 3'd1 && s.bop <= 3'd6 && s.jmp != 2'b01 && s.jmp != 2'b10);
      s.hold  = ($urandom_range(0, 4) == 0);
      s.ack   = ($urandom_range(0, 9) < 7);
      s.dpc4  = $urandom;
      s.rs    = pick();
      s.rt    = $urandom_range(0, 1) ? s.rs : pick();
      s.imm   = 16'($urandom);
      s.idx   = 26'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
